// File: rtl/button_pkg.sv
`default_nettype none
// button_pkg: state encoding and elaboration-time helpers for the button event decoder.
package button_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    GAP    = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } state_t;

  function automatic int ms_to_cycles(input int freq, input int ms);
    return (freq / 1000) * ms;
  endfunction

  function automatic int clog2(input int value);
    int result;
    int x;
    result = 0;
    x = value - 1;
    while (x > 0) begin
      result = result + 1;
      x = x >> 1;
    end
    return result;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_event_decoder_if.sv
`default_nettype none
// button_event_decoder_if: debounced level in, classified one-cycle events out.
interface button_event_decoder_if;
  logic debounce;
  logic held;
  logic press_p;
  logic release_p;
  logic click_p;
  logic dclick_p;
  logic long_p;
  logic repeat_p;

  modport master (
    output debounce,
    input  held, press_p, release_p, click_p, dclick_p, long_p, repeat_p
  );

  modport slave (
    input  debounce,
    output held, press_p, release_p, click_p, dclick_p, long_p, repeat_p
  );
endinterface
`default_nettype wire

// File: rtl/button_edge_detect.sv
`default_nettype none
// button_edge_detect: one-cycle delayed copy of a level plus rise/fall strobes.
module button_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  // Reset loads the live level so an input already high through reset produces no rise.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q <= d;
    end else begin
      q <= d;
    end
  end

  assign rise = d & ~q;
  assign fall = ~d & q;

endmodule
`default_nettype wire

// File: rtl/button_event_decoder.sv
`default_nettype none
// button_event_decoder: classifies a debounced button level into press, release, click,
// double click, long press and auto-repeat pulses.
module button_event_decoder
  import button_pkg::*;
#(
  parameter int CLK_FREQUENCY   = 66000000,
  parameter int LONG_PRESS_MS   = 1000,
  parameter int DOUBLE_CLICK_MS = 250,
  parameter int REPEAT_MS       = 100
) (
  input  logic                  clk,
  input  logic                  reset_n,
  button_event_decoder_if.slave bus
);

  localparam int LONG_C = ms_to_cycles(CLK_FREQUENCY, LONG_PRESS_MS);
  localparam int DBL_C  = ms_to_cycles(CLK_FREQUENCY, DOUBLE_CLICK_MS);
  localparam int REP_C  = ms_to_cycles(CLK_FREQUENCY, REPEAT_MS);
  localparam int TW     = clog2(max3(LONG_C, DBL_C, REP_C) + 1);

  localparam logic [TW-1:0] LONG_END = TW'(LONG_C - 1);
  localparam logic [TW-1:0] DBL_END  = TW'(DBL_C - 1);
  localparam logic [TW-1:0] REP_END  = TW'(REP_C - 1);
  localparam logic [TW-1:0] TMAX     = '1;

  if (LONG_C < 2 || DBL_C < 2 || REP_C < 2) begin : g_param_check
    $error("button_event_decoder: every derived cycle count must be at least 2");
  end

  logic    rise, fall, unused_deb_q;
  state_t  state, state_nxt;
  logic [TW-1:0] timer, timer_nxt, timer_inc;
  logic    bad_state;
  logic    held_nxt, press_nxt, release_nxt, click_nxt, dclick_nxt, long_nxt, repeat_nxt;

  button_edge_detect u_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (bus.debounce),
    .q       (unused_deb_q),
    .rise    (rise),
    .fall    (fall)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      timer         <= '0;
      bus.held      <= 1'b0;
      bus.press_p   <= 1'b0;
      bus.release_p <= 1'b0;
      bus.click_p   <= 1'b0;
      bus.dclick_p  <= 1'b0;
      bus.long_p    <= 1'b0;
      bus.repeat_p  <= 1'b0;
    end else begin
      state         <= state_nxt;
      timer         <= timer_nxt;
      bus.held      <= held_nxt;
      bus.press_p   <= press_nxt;
      bus.release_p <= release_nxt;
      bus.click_p   <= click_nxt;
      bus.dclick_p  <= dclick_nxt;
      bus.long_p    <= long_nxt;
      bus.repeat_p  <= repeat_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bad_state   = 1'b0;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    click_nxt   = 1'b0;
    dclick_nxt  = 1'b0;
    long_nxt    = 1'b0;
    repeat_nxt  = 1'b0;
    timer_inc   = (timer == TMAX) ? timer : timer + TW'(1);

    // Release/press edges are tested before timer expiry so they win ties.
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = PRESS1;
          press_nxt = 1'b1;
        end
      end
      PRESS1: begin
        if (fall) begin
          state_nxt   = GAP;
          release_nxt = 1'b1;
        end else if (timer == LONG_END) begin
          state_nxt = LONG;
          long_nxt  = 1'b1;
        end
      end
      GAP: begin
        if (rise) begin
          state_nxt = PRESS2;
          press_nxt = 1'b1;
        end else if (timer == DBL_END) begin
          state_nxt = IDLE;
          click_nxt = 1'b1;
        end
      end
      PRESS2: begin
        if (fall) begin
          state_nxt   = IDLE;
          release_nxt = 1'b1;
          dclick_nxt  = 1'b1;
        end
      end
      LONG: begin
        if (fall) begin
          state_nxt   = IDLE;
          release_nxt = 1'b1;
        end else if (timer == REP_END) begin
          repeat_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        bad_state = 1'b1;
      end
    endcase

    if (bad_state) begin
      timer_nxt = TMAX;
    end else if (state_nxt != state || repeat_nxt) begin
      timer_nxt = '0;
    end else begin
      timer_nxt = timer_inc;
    end

    held_nxt = (state_nxt == PRESS1) || (state_nxt == PRESS2) || (state_nxt == LONG);
  end

endmodule
`default_nettype wire

// File: tb/tb_button_event_decoder.sv
`default_nettype none
// tb_button_event_decoder: directed scenarios plus random stimulus against a timestamp-based model.
module tb_button_event_decoder;

  localparam int L = 20;
  localparam int D = 8;
  localparam int R = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  button_event_decoder_if bif();

  button_event_decoder #(
    .CLK_FREQUENCY   (1000),
    .LONG_PRESS_MS   (L),
    .DOUBLE_CLICK_MS (D),
    .REPEAT_MS       (R)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit started = 0;

  // Model: a press sequence is described by timestamps instead of states.
  bit m_prev, m_active, m_is_held, m_long_fired;
  int m_npress, m_t_press, m_t_rel, m_t_long;
  logic e_held, e_press, e_rel, e_click, e_dclick, e_long, e_rep;

  always @(posedge clk) begin
    bit rise, fall, d;
    cyc = cyc + 1;
    d = bif.debounce;
    rise = d & ~m_prev;
    fall = ~d & m_prev;
    {e_press, e_rel, e_click, e_dclick, e_long, e_rep} = '0;
    if (!reset_n) begin
      m_active = 0;
      m_is_held = 0;
    end else if (!m_active) begin
      if (rise) begin
        m_active = 1; m_is_held = 1; m_npress = 1; m_long_fired = 0;
        m_t_press = cyc; e_press = 1;
      end
    end else if (m_is_held) begin
      if (fall) begin
        e_rel = 1; m_is_held = 0;
        if (m_npress == 2) begin e_dclick = 1; m_active = 0; end
        else if (m_long_fired) m_active = 0;
        else m_t_rel = cyc;
      end else if (m_npress == 1 && !m_long_fired && cyc - m_t_press == L) begin
        e_long = 1; m_long_fired = 1; m_t_long = cyc;
      end else if (m_long_fired && (cyc - m_t_long) % R == 0) begin
        e_rep = 1;
      end
    end else begin
      if (rise) begin
        e_press = 1; m_npress = 2; m_is_held = 1;
      end else if (cyc - m_t_rel == D) begin
        e_click = 1; m_active = 0;
      end
    end
    e_held = m_active & m_is_held;
    m_prev = d;
    started = 1;
  end

  // Event log from the DUT for the directed timing checks.
  int n_press, n_rel, n_click, n_dclick, n_long, n_rep;
  int tp_first, tr_first, tr_last, tc, td, tl, trep_first;

  always @(negedge clk) begin
    if (started) begin
      checks = checks + 1;
      if ({bif.held, bif.press_p, bif.release_p, bif.click_p, bif.dclick_p, bif.long_p, bif.repeat_p}
          !== {e_held, e_press, e_rel, e_click, e_dclick, e_long, e_rep}) begin
        errors = errors + 1;
        $display("FAIL cycle_compare cyc=%0d actual(held,press,rel,click,dclick,long,rep)=%b%b%b%b%b%b%b required=%b%b%b%b%b%b%b",
                 cyc, bif.held, bif.press_p, bif.release_p, bif.click_p, bif.dclick_p, bif.long_p, bif.repeat_p,
                 e_held, e_press, e_rel, e_click, e_dclick, e_long, e_rep);
      end
      if (bif.press_p === 1'b1) begin
        if (n_press == 0) tp_first = cyc;
        n_press = n_press + 1;
      end
      if (bif.release_p === 1'b1) begin
        if (n_rel == 0) tr_first = cyc;
        tr_last = cyc;
        n_rel = n_rel + 1;
      end
      if (bif.click_p === 1'b1) begin tc = cyc; n_click = n_click + 1; end
      if (bif.dclick_p === 1'b1) begin td = cyc; n_dclick = n_dclick + 1; end
      if (bif.long_p === 1'b1) begin tl = cyc; n_long = n_long + 1; end
      if (bif.repeat_p === 1'b1) begin
        if (n_rep == 0) trep_first = cyc;
        n_rep = n_rep + 1;
      end
    end
  end

  task automatic check(input string name, input int actual, input int required);
    checks = checks + 1;
    if (actual !== required) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  task automatic clear_log();
    n_press = 0; n_rel = 0; n_click = 0; n_dclick = 0; n_long = 0; n_rep = 0;
    tp_first = -1; tr_first = -1; tr_last = -1; tc = -1; td = -1; tl = -1; trep_first = -1;
  endtask

  task automatic drive(input bit v, input int n);
    bif.debounce = v;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bif.debounce = 1'b0;
    reset_n = 1'b0;
    clear_log();
    repeat (3) @(negedge clk);
    check("reset_held", int'(bif.held), 0);
    check("reset_press", int'(bif.press_p), 0);
    reset_n = 1'b1;
    drive(0, 3);

    // 1: single click
    clear_log();
    drive(1, 5); drive(0, 15);
    check("t1_press_count", n_press, 1);
    check("t1_release_delay", tr_first - tp_first, 5);
    check("t1_click_delay", tc - tr_first, 8);
    check("t1_dclick_count", n_dclick, 0);
    check("t1_long_count", n_long, 0);

    // 2: double click
    clear_log();
    drive(1, 4); drive(0, 3); drive(1, 4); drive(0, 15);
    check("t2_press_count", n_press, 2);
    check("t2_click_count", n_click, 0);
    check("t2_dclick_count", n_dclick, 1);
    check("t2_dclick_with_release", td - tr_last, 0);

    // 3: long press with repeats
    clear_log();
    drive(1, 32); drive(0, 15);
    check("t3_long_delay", tl - tp_first, 20);
    check("t3_repeat_count", n_rep, 2);
    check("t3_repeat_delay", trep_first - tl, 5);
    check("t3_release_count", n_rel, 1);
    check("t3_click_count", n_click, 0);

    // 4: fall on long expiry, rise on gap expiry
    clear_log();
    drive(1, 20); drive(0, 8); drive(1, 4); drive(0, 15);
    check("t4_long_count", n_long, 0);
    check("t4_release_delay", tr_first - tp_first, 20);
    check("t4_click_count", n_click, 0);
    check("t4_dclick_count", n_dclick, 1);
    check("t4_press_count", n_press, 2);

    // 5: button held through reset
    clear_log();
    bif.debounce = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    drive(1, 4); drive(0, 3);
    check("t5_no_press", n_press, 0);
    check("t5_no_release", n_rel, 0);
    drive(1, 4); drive(0, 12);
    check("t5_next_press", n_press, 1);
    check("t5_next_click", n_click, 1);

    // 6: reset in GAP, then reset in LONG
    clear_log();
    drive(1, 3); drive(0, 3);
    reset_n = 1'b0;
    @(negedge clk);
    check("t6_gap_reset_held", int'(bif.held), 0);
    reset_n = 1'b1;
    drive(0, 12);
    check("t6_gap_no_click", n_click, 0);
    clear_log();
    drive(1, 25);
    reset_n = 1'b0;
    @(negedge clk);
    check("t6_long_reset_held", int'(bif.held), 0);
    reset_n = 1'b1;
    drive(1, 10); drive(0, 5);
    check("t6_long_count", n_long, 1);
    check("t6_no_repeat", n_rep, 0);
    check("t6_single_press", n_press, 1);
    check("t6_no_release", n_rel, 0);

    // Random runs with occasional resets, checked cycle by cycle
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        reset_n = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
        reset_n = 1'b1;
      end
      drive(1'($urandom_range(0, 1)), $urandom_range(1, 30));
    end
    drive(0, 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
